// File: rtl/btn_event_decoder.sv
// Button gesture classifier: short, long and double presses from a debounced level.
// Optional saturating press counter on press_cnt_o when BTN_EVENT_CNT_EN is defined.
module btn_event_decoder #(
  parameter int LONG_CYCLES = 100,
  parameter int GAP_CYCLES  = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       db_level_i,
  input  logic       db_tick_i,
  output logic       short_o,
  output logic       long_o,
  output logic       double_o,
  output logic       busy_o
`ifdef BTN_EVENT_CNT_EN
  ,
  output logic [7:0] press_cnt_o
`endif
);

  localparam int MAXC = (LONG_CYCLES > GAP_CYCLES) ?
                        LONG_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    HELD,
    GAP,
    PRESS2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;

  logic r_short;
  logic r_long;
  logic r_double;
  logic r_busy;
  logic w_short_nxt;
  logic w_long_nxt;
  logic w_double_nxt;
  logic w_busy_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Release beats the long threshold; a tick beats the gap timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    unique case (r_state)
      IDLE: begin
        if (db_tick_i) begin
          w_state_nxt = PRESS1;
          w_tmr_nxt   = '0;
        end
      end
      PRESS1: begin
        if (!db_level_i) begin
          w_state_nxt = GAP;
          w_tmr_nxt   = '0;
        end else if (r_tmr == LONG_LAST) begin
          w_state_nxt = HELD;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      HELD: begin
        if (!db_level_i) w_state_nxt = IDLE;
      end
      GAP: begin
        if (db_tick_i) begin
          w_state_nxt = PRESS2;
        end else if (r_tmr == GAP_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      PRESS2: begin
        if (!db_level_i) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_double_nxt = 1'b0;
    w_busy_nxt   = (w_state_nxt != IDLE);
    unique case (r_state)
      PRESS1: begin
        w_long_nxt = db_level_i && (r_tmr == LONG_LAST);
      end
      GAP: begin
        w_double_nxt = db_tick_i;
        w_short_nxt  = !db_tick_i && (r_tmr == GAP_LAST);
      end
      default: begin
        w_short_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= w_short_nxt;
      r_long   <= w_long_nxt;
      r_double <= w_double_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign short_o  = r_short;
  assign long_o   = r_long;
  assign double_o = r_double;
  assign busy_o   = r_busy;

`ifdef BTN_EVENT_CNT_EN
  logic [7:0] r_cnt;
  logic       w_acc;

  assign w_acc = db_tick_i &&
                 ((r_state == IDLE) || (r_state == GAP));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_acc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign press_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Gesture-level bench for btn_event_decoder: expected pulses are
// computed per gesture from hold/gap lengths, then compared every cycle.
module tb_btn_event_decoder;

  localparam int L = 100;
  localparam int G = 50;
  localparam int N = 50000;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic db_level_i;
  logic db_tick_i;
  logic short_o;
  logic long_o;
  logic double_o;
  logic busy_o;
`ifdef BTN_EVENT_CNT_EN
  logic [7:0] press_cnt_o;
`endif

  btn_event_decoder #(
    .LONG_CYCLES(L),
    .GAP_CYCLES (G)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .db_level_i (db_level_i),
    .db_tick_i  (db_tick_i),
    .short_o    (short_o),
    .long_o     (long_o),
    .double_o   (double_o),
    .busy_o     (busy_o)
`ifdef BTN_EVENT_CNT_EN
    ,
    .press_cnt_o(press_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic       lvl_a  [N];
  logic       tick_a [N];
  logic       busy_a [N];
  logic       acc_a  [N];
  logic [2:0] ev_a   [N];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int len = 0;
  int lenA = 0;
  int n_short = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  // One gesture: first press h1 cycles, then g2 low cycles before a
  // second press of h2 cycles (g2 outside 1..G means no second press).
  task automatic gen(input int h1, input int g2,
                     input int h2, input int idle);
    int t0;
    int t2;
    int nx;
    t0 = len;
    for (int i = 0; i < h1; i++) begin
      lvl_a[t0+i]  = 1'b1;
      tick_a[t0+i] = (i == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
    end
    acc_a[t0] = 1'b1;
    if (h1 > L) begin
      ev_a[t0+L+1] = 3'b010;
      nx = t0 + h1;
    end else if (g2 >= 1 && g2 <= G) begin
      t2 = t0 + h1 + g2;
      for (int i = 0; i < h2; i++) begin
        lvl_a[t2+i]  = 1'b1;
        tick_a[t2+i] = (i == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
      end
      acc_a[t2]   = 1'b1;
      ev_a[t2+1]  = 3'b100;
      nx = t2 + h2;
    end else begin
      ev_a[t0+h1+G+1] = 3'b001;
      nx = t0 + h1 + G;
    end
    for (int c = t0 + 1; c <= nx; c++) busy_a[c] = 1'b1;
    len = nx + 1 + idle;
  endtask

  function automatic int pick_h1();
    case ($urandom_range(0, 5))
      0: return 1;
      1: return 2;
      2: return L - 1;
      3: return L;
      4: return L + 1;
      default: return int'($urandom_range(1, 250));
    endcase
  endfunction

  function automatic int pick_g2();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return G - 1;
      3: return G;
      4: return G + 1;
      default: return int'($urandom_range(1, 70));
    endcase
  endfunction

  task automatic run(input int a, input int b);
`ifdef BTN_EVENT_CNT_EN
    int m_cnt;
    m_cnt = 0;
`endif
    for (int c = a; c < b; c++) begin
      cyc = c;
      chk("ev", {29'd0, double_o, long_o, short_o}, {29'd0, ev_a[c]});
      chk("busy", {31'd0, busy_o}, {31'd0, busy_a[c]});
`ifdef BTN_EVENT_CNT_EN
      chk("cnt", {24'd0, press_cnt_o}, m_cnt);
`endif
      if (short_o === 1'b1) n_short++;
      db_level_i = lvl_a[c];
      db_tick_i  = tick_a[c];
      @(posedge clk_i);
      #1;
`ifdef BTN_EVENT_CNT_EN
      if (acc_a[c] && m_cnt < 255) m_cnt++;
`endif
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {28'd0, busy_o, double_o, long_o, short_o}, 32'd0);
`ifdef BTN_EVENT_CNT_EN
    chk({tag, "_cnt"}, {24'd0, press_cnt_o}, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      lvl_a[i]  = 1'b0;
      tick_a[i] = 1'b0;
      busy_a[i] = 1'b0;
      acc_a[i]  = 1'b0;
      ev_a[i]   = 3'b000;
    end

    len = 3;
    gen(20, 0, 0, 3);
    gen(300, 0, 0, 3);
    gen(20, 10, 20, 3);
    gen(20, G, 20, 3);
    gen(20, G + 1, 0, 0);
    gen(L, 0, 0, 0);
    gen(L + 1, 0, 0, 2);
    gen(L - 1, 1, L + 20, 0);
    for (int k = 0; k < 40; k++) begin
      gen(pick_h1(), pick_g2(), int'($urandom_range(1, 150)),
          int'($urandom_range(0, 4)));
    end
    len  = len + 5;
    lenA = len;
    for (int k = 0; k < 300; k++) begin
      gen(int'($urandom_range(1, 20)), 0, 0,
          int'($urandom_range(0, 4)));
    end
    len = len + 5;

    rst_ni     = 1'b0;
    db_level_i = 1'b0;
    db_tick_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_zero("rst");
    rst_ni = 1'b1;

    run(0, lenA);

    cyc = lenA;
    db_level_i = 1'b1;
    db_tick_i  = 1'b1;
    @(posedge clk_i);
    #1;
    db_tick_i = 1'b0;
    repeat (19) begin
      @(posedge clk_i);
      #1;
    end
    db_level_i = 1'b0;
    repeat (31) begin
      @(posedge clk_i);
      #1;
    end
    chk("busy_pre", {31'd0, busy_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(posedge clk_i);
    #1;
    chk_zero("mid_rst_hold");
    rst_ni  = 1'b1;
    n_short = 0;

    run(lenA, len);
    chk("n_short", n_short, 32'd300);
`ifdef BTN_EVENT_CNT_EN
    chk("cnt_sat", {24'd0, press_cnt_o}, 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
- REQ-001: LONG_CYCLES, 100, hold duration in clk_i cycles (>=2) that classifies a press as long.
- REQ-002: GAP_CYCLES, 50, maximum release-to-second-press gap in clk_i cycles (>=2) that classifies a double press.
- REQ-003: clk_i  input  1  single clock; all logic on rising edge.
- REQ-004: rst_ni  input  1  asynchronous, active-low reset.
- REQ-005: db_level_i  input  1  debounced switch level from the debouncer, synchronous to clk_i.
- REQ-006: db_tick_i  input  1  one-cycle pulse from the debouncer on each debounced rising edge.
- REQ-007: short_o  output  1  one-cycle pulse, single short press.
- REQ-008: long_o  output  1  one-cycle pulse, long press.
- REQ-009: double_o  output  1  one-cycle pulse, double press.
- REQ-010: busy_o  output  1  high whenever the FSM is not in IDLE.
- REQ-011: press_cnt_o  output  8  saturating count of accepted presses; present only with BTN_EVENT_CNT_EN.

Function
- REQ-012: FSM states: IDLE, PRESS1, HELD, GAP, PRESS2; one shared timer, width $clog2(max(LONG_CYCLES,GAP_CYCLES)+1).
- REQ-013: IDLE: db_tick_i=1 -> PRESS1, timer cleared to 0; otherwise stay.
- REQ-014: PRESS1: timer increments each cycle; db_level_i=0 with timer < LONG_CYCLES-1 -> GAP, timer cleared.
- REQ-015: PRESS1: timer = LONG_CYCLES-1 and db_level_i=1 -> HELD, long_o pulses in the next cycle.
- REQ-016: PRESS1: timer = LONG_CYCLES-1 and db_level_i=0 in the same cycle -> release wins, GAP, no long_o.
- REQ-017: HELD: db_level_i=0 -> IDLE; no further pulses regardless of hold duration.
- REQ-018: GAP: timer increments; db_tick_i=1 -> PRESS2, double_o pulses next cycle.
- REQ-019: GAP: timer = GAP_CYCLES-1 without db_tick_i -> IDLE, short_o pulses next cycle.
- REQ-020: GAP: db_tick_i and timeout in the same cycle -> tick wins; double_o, no short_o.
- REQ-021: PRESS2: db_level_i=0 -> IDLE; length of second press is not classified.
- REQ-022: db_tick_i in PRESS1, HELD or PRESS2 is ignored.
- REQ-023: All outputs registered; exactly one of short_o/long_o/double_o per classified gesture, never two in one cycle.
- REQ-024: Event latency: pulse appears exactly one clk_i cycle after the deciding condition is sampled.
- REQ-025: An accepted tick in IDLE may coincide with a pulse being output for the previous gesture; both take effect.

Reset
- REQ-026: rst_ni=0 forces IDLE, timer=0, short_o=long_o=double_o=busy_o=0, press_cnt_o=0, immediately and asynchronously.
- REQ-027: Reset mid-gesture discards the gesture; no pulse is emitted after reset release.
- REQ-028: After rst_ni deasserts, the first db_tick_i is accepted on the first rising clk_i edge.

Configuration
- REQ-029: Macro BTN_EVENT_CNT_EN defined: press_cnt_o exists and increments by 1 on every db_tick_i accepted in IDLE or GAP, saturating at 255.
- REQ-030: Macro BTN_EVENT_CNT_EN undefined: press_cnt_o port and counter logic absent; all other behaviour identical.

Verification (LONG_CYCLES=100, GAP_CYCLES=50)
- REQ-031: tick + level high 20 cycles, then low for 60 cycles -> one short_o, 51 cycles after release sampled; no long_o or double_o.
- REQ-032: tick + level held 300 cycles -> one long_o, 101 cycles after tick; nothing more on release.
- REQ-033: press 20, release 10, second tick + press 20 -> one double_o, one cycle after second tick; no short_o; press_cnt_o=2 with BTN_EVENT_CNT_EN.
- REQ-034: second tick exactly on GAP timeout cycle (49 cycles after GAP entry) -> double_o only.
- REQ-035: rst_ni pulsed low at cycle 30 of GAP -> all outputs 0 immediately, no pulse after release, next tick classified normally.
- REQ-036: 300 short presses with BTN_EVENT_CNT_EN -> press_cnt_o=255, 300 short_o pulses.
